continuous_sampler: RTL and testbench
=====================================

// Module: continuous_sampler
// PURPOSE
//  Multi-channel successor to single-sensor continuous monitoring. Periodically polls up to NCH
//  sensor channels round-robin through a req/ack sensor port, then hands each sample plus its
//  channel id to the UART TX path. Sits between the sensor readers and the TX framer.
//  Flags period overruns and sensor ack timeouts.
// PARAMETERS
//  NCH        4         number of sensor channels (>=1)
//  DATA_W     8         sample width
//  PERIOD_W   24        width of period register (clock ticks)
//  ACK_TO     100000    max cycles to wait for sns_ack before timeout
// PORTS
//  clk        in   1          clock
//  rst        in   1          async reset, active-low
//  cont_en    in   1          1 = continuous sampling enabled
//  ch_mask    in   NCH        per-channel enable
//  period     in   PERIOD_W   sample interval in clk cycles (0 treated as 1)
//  sns_req    out  1          sensor read request (level)
//  sns_ch     out  CHW        channel being read, CHW=max(1,$clog2(NCH))
//  sns_ack    in   1          1-cycle pulse: sns_data valid
//  sns_data   in   DATA_W     sensor sample
//  tx_ready   in   1          TX idle
//  tx_start   out  1          1-cycle pulse: start frame
//  tx_data    out  DATA_W     sample to send; stable from tx_start until next capture
//  tx_ch      out  CHW        channel id of tx_data
//  err_clr    in   1          sync clear of sticky flags
//  overrun    out  1          sticky: tick arrived while busy
//  timeout    out  1          sticky: sensor ack timeout
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, counter=period-1 load deferred to first enabled cycle,
//   FSM=IDLE, rr pointer = NCH-1 (first pick is ch0).
//  Period counter: while cont_en=1 counts down; at 0 emits internal tick, reloads period-1.
//   cont_en=0 holds counter at reload value. period change takes effect at next reload.
//  FSM IDLE -> WAIT_TICK when cont_en=1.
//  WAIT_TICK: on tick, if ch_mask!=0 pick next enabled channel after rr pointer (wraps
//   NCH-1 -> 0), update pointer, -> REQ; if ch_mask==0 tick ignored, no flag.
//  REQ: sns_req=1, sns_ch=picked. On sns_ack: capture sns_data into tx_data, ch into tx_ch,
//   sns_req=0 next cycle, -> SEND. ACK_TO cycles w/o ack: timeout<=1, sns_req=0, -> WAIT_TICK.
//  SEND: when tx_ready=1 pulse tx_start one cycle -> WAIT_TX.
//  WAIT_TX: wait tx_ready=0 then tx_ready=1 (frame done) -> WAIT_TICK.
//  Tick in any state other than WAIT_TICK: overrun<=1, tick dropped (never queued).
//  Latency: tick -> sns_req = 1 cycle; sns_ack -> tx_start = 1 cycle if tx_ready=1.
//  cont_en falling: REQ/SEND/WAIT_TICK -> IDLE next cycle (sns_req drops, no tx_start);
//   WAIT_TX completes its frame then -> IDLE.
//  ch_mask bit cleared mid-read: current read completes; affects next pick only.
//  err_clr and set in same cycle: set wins.
//  sns_ack outside REQ ignored.
// STRUCTURE
//  Package continuous_pkg: state enum (IDLE,WAIT_TICK,REQ,SEND,WAIT_TX), CHW helper function.
//  Sub-module continuous_rr_arbiter: combinational next-enabled-channel pick from mask+pointer.
//  Top: period counter, ack timeout counter, FSM, output/flag registers.
// TESTING
//  NCH=4, period=10, mask=4'b1111, sensor acks 2 cycles after req, tx_ready drops 1 cycle
//   after start for 3 cycles -> tx_ch sequence 0,1,2,3,0; tx_start spaced 10 cycles.
//  mask=4'b1010 -> tx_ch sequence 1,3,1,3; mask=0 -> no sns_req, overrun stays 0.
//  Sensor never acks, ACK_TO=20 -> sns_req high exactly 20 cycles, timeout=1, next tick
//   polls next channel; err_clr -> timeout=0.
//  period=4, tx_ready held 0 for 12 cycles -> overrun=1, exactly one tx_start after release.
//  sns_data=8'hA5 on ch2 -> tx_data=8'hA5, tx_ch=2 with tx_start 1 cycle after ack.
//  rst low during REQ -> sns_req, tx_start, flags 0 immediately; next poll starts at ch0.

Source files
------------

// File: rtl/continuous_pkg.sv
// Shared types and helpers for the continuous multi-channel sampler.
package continuous_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_TX   = 3'd4
    } state_t;

    // Channel-id width; a single channel still needs one id bit.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/continuous_rr_arbiter.sv
// Round-robin pick: first enabled channel strictly after the pointer, wrapping to 0.
module continuous_rr_arbiter
    import continuous_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = chw(NCH)
) (
    input  logic [NCH-1:0] i_mask,
    input  logic [CHW-1:0] i_ptr,
    output logic [CHW-1:0] o_pick,
    output logic           o_valid
);

    logic [CHW-1:0] w_pick;
    logic [CHW-1:0] w_idx;
    logic           w_valid;

    // Scan from farthest to nearest so the nearest enabled channel is written last.
    always_comb begin
        w_pick  = {CHW{1'b0}};
        w_valid = 1'b0;
        w_idx   = {CHW{1'b0}};
        for (int i = NCH; i >= 1; i--) begin
            w_idx   = CHW'((int'(i_ptr) + i) % NCH);
            w_pick  = i_mask[w_idx] ? w_idx : w_pick;
            w_valid = w_valid | i_mask[w_idx];
        end
    end

    assign o_pick  = w_pick;
    assign o_valid = w_valid;

endmodule

// File: rtl/continuous_sampler.sv
// Periodic round-robin sensor poller feeding the UART TX framer, with overrun
// and ack-timeout sticky flags.
module continuous_sampler
    import continuous_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 24,
    parameter int ACK_TO   = 100000,
    parameter int CHW      = chw(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cont_en,
    input  logic [NCH-1:0]      i_ch_mask,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_sns_req,
    output logic [CHW-1:0]      o_sns_ch,
    input  logic                i_sns_ack,
    input  logic [DATA_W-1:0]   i_sns_data,
    input  logic                i_tx_ready,
    output logic                o_tx_start,
    output logic [DATA_W-1:0]   o_tx_data,
    output logic [CHW-1:0]      o_tx_ch,
    input  logic                i_err_clr,
    output logic                o_overrun,
    output logic                o_timeout
);

    localparam int TOW = $clog2(ACK_TO + 1);

    state_t              r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_armed;
    logic [CHW-1:0]      r_ptr;
    logic [TOW-1:0]      r_to_cnt;
    logic                r_seen_busy;
    logic                r_sns_req;
    logic [CHW-1:0]      r_sns_ch;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic [CHW-1:0]      r_tx_ch;
    logic                r_overrun;
    logic                r_timeout;

    logic [PERIOD_W-1:0] w_reload;
    logic                w_tick;
    logic [CHW-1:0]      w_pick;
    logic                w_pick_valid;
    logic                w_ack_expired;
    logic                w_set_ovr;

    continuous_rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .i_mask  (i_ch_mask),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    // A zero period behaves like a period of one.
    assign w_reload = (i_period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                                                     : i_period - PERIOD_W'(1);
    assign w_tick   = i_cont_en & r_armed & (r_cnt == {PERIOD_W{1'b0}});

    assign w_ack_expired = (r_state == REQ) & i_cont_en & ~i_sns_ack
                         & (r_to_cnt == TOW'(ACK_TO - 1));
    assign w_set_ovr     = w_tick & (r_state != WAIT_TICK);

    // Period counter: first enabled cycle loads, then counts down and reloads at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= {PERIOD_W{1'b0}};
            r_armed <= 1'b0;
        end else if (!i_cont_en) begin
            r_cnt   <= w_reload;
            r_armed <= 1'b0;
        end else if (!r_armed || w_tick) begin
            r_cnt   <= w_reload;
            r_armed <= 1'b1;
        end else begin
            r_cnt   <= r_cnt - PERIOD_W'(1);
            r_armed <= 1'b1;
        end
    end

    // Poll sequencer and registered sensor/TX outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= CHW'(NCH - 1);
            r_to_cnt    <= {TOW{1'b0}};
            r_seen_busy <= 1'b0;
            r_sns_req   <= 1'b0;
            r_sns_ch    <= {CHW{1'b0}};
            r_tx_start  <= 1'b0;
            r_tx_data   <= {DATA_W{1'b0}};
            r_tx_ch     <= {CHW{1'b0}};
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cont_en) begin
                        r_state <= WAIT_TICK;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT_TICK: begin
                    if (!i_cont_en) begin
                        r_state <= IDLE;
                    end else if (w_tick && w_pick_valid) begin
                        r_ptr     <= w_pick;
                        r_sns_ch  <= w_pick;
                        r_sns_req <= 1'b1;
                        r_to_cnt  <= {TOW{1'b0}};
                        r_state   <= REQ;
                    end else begin
                        r_state <= WAIT_TICK;
                    end
                end
                REQ: begin
                    if (!i_cont_en) begin
                        r_sns_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (i_sns_ack) begin
                        r_tx_data <= i_sns_data;
                        r_tx_ch   <= r_sns_ch;
                        r_sns_req <= 1'b0;
                        // An idle TX gets the start pulse straight away, skipping SEND.
                        if (i_tx_ready) begin
                            r_tx_start  <= 1'b1;
                            r_seen_busy <= 1'b0;
                            r_state     <= WAIT_TX;
                        end else begin
                            r_state <= SEND;
                        end
                    end else if (w_ack_expired) begin
                        r_sns_req <= 1'b0;
                        r_state   <= WAIT_TICK;
                    end else begin
                        r_to_cnt <= r_to_cnt + TOW'(1);
                    end
                end
                SEND: begin
                    if (!i_cont_en) begin
                        r_state <= IDLE;
                    end else if (i_tx_ready) begin
                        r_tx_start  <= 1'b1;
                        r_seen_busy <= 1'b0;
                        r_state     <= WAIT_TX;
                    end else begin
                        r_state <= SEND;
                    end
                end
                WAIT_TX: begin
                    // Frame is done only after TX has gone busy and come back.
                    if (!i_tx_ready) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_state <= i_cont_en ? WAIT_TICK : IDLE;
                    end else begin
                        r_state <= WAIT_TX;
                    end
                end
                default: begin
                    r_sns_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (i_err_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
            if (w_ack_expired) begin
                r_timeout <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign o_sns_req  = r_sns_req;
    assign o_sns_ch   = r_sns_ch;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_tx_ch    = r_tx_ch;
    assign o_overrun  = r_overrun;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_continuous_sampler.sv
// Scoreboard bench for continuous_sampler: sensor and TX models, expected frames
// queued by the stimulus and checked by an independent monitor.
module tb_continuous_sampler;

    localparam int NCH      = 4;
    localparam int DATA_W   = 8;
    localparam int PERIOD_W = 24;
    localparam int ACK_TO   = 20;
    localparam int CHW      = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cont_en = 1'b0;
    logic [NCH-1:0]      ch_mask = 4'b0000;
    logic [PERIOD_W-1:0] period = 24'd10;
    logic                sns_req;
    logic [CHW-1:0]      sns_ch;
    logic                sns_ack;
    logic [DATA_W-1:0]   sns_data;
    logic                tx_ready;
    logic                tx_start;
    logic [DATA_W-1:0]   tx_data;
    logic [CHW-1:0]      tx_ch;
    logic                err_clr = 1'b0;
    logic                overrun;
    logic                timeout;

    typedef struct packed {
        logic [CHW-1:0]    ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          start_cyc_q[$];
    int          cyc = 0;
    int          n_starts = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          last_ack_cyc = 0;
    int          req_age = 0;
    int          busy = 0;
    logic        sns_en = 1'b1;
    logic        tx_block = 1'b0;
    logic [7:0]  chan_data [NCH];

    continuous_sampler #(
        .NCH      (NCH),
        .DATA_W   (DATA_W),
        .PERIOD_W (PERIOD_W),
        .ACK_TO   (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cont_en  (cont_en),
        .i_ch_mask  (ch_mask),
        .i_period   (period),
        .o_sns_req  (sns_req),
        .o_sns_ch   (sns_ch),
        .i_sns_ack  (sns_ack),
        .i_sns_data (sns_data),
        .i_tx_ready (tx_ready),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_tx_ch    (tx_ch),
        .i_err_clr  (err_clr),
        .o_overrun  (overrun),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ch);
        exp_t e;
        e.ch   = CHW'(ch);
        e.data = chan_data[ch];
        exp_q.push_back(e);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(n_starts >= target), 32'(1));
    endtask

    task automatic wait_req(input int budget, input string name);
        int k = 0;
        while (!sns_req && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(sns_req), 32'(1));
    endtask

    // Sensor: acks two cycles after the request is first seen, unless muted.
    initial begin
        sns_ack  = 1'b0;
        sns_data = 8'h00;
        forever begin
            @(negedge clk);
            sns_ack = 1'b0;
            if (rst && sns_req && sns_en) begin
                req_age++;
                if (req_age == 2) begin
                    sns_ack      = 1'b1;
                    sns_data     = chan_data[sns_ch];
                    last_ack_cyc = cyc;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // TX: goes busy one cycle after tx_start for three cycles; tx_block forces busy.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) busy = 3;
            else if (busy > 0) busy--;
            tx_ready = (busy == 0) && !tx_block;
        end
    end

    // Monitor: every tx_start must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && tx_start) begin
            n_starts++;
            start_cyc_q.push_back(cyc);
            check("tx_start_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("tx_ch", 32'(tx_ch), 32'(mon_e.ch));
                check("tx_data", 32'(tx_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int hi;
        chan_data[0] = 8'h3C;
        chan_data[1] = 8'h5A;
        chan_data[2] = 8'hA5;
        chan_data[3] = 8'hC3;

        repeat (3) @(negedge clk);
        check("rst_sns_req", 32'(sns_req), 32'(0));
        check("rst_sns_ch", 32'(sns_ch), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_tx_ch", 32'(tx_ch), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // All channels, period 10: 0,1,2,3,0 spaced 10 cycles.
        period = 24'd10;
        ch_mask = 4'b1111;
        start_cyc_q.delete();
        base = n_starts;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        cont_en = 1'b1;
        wait_starts(base + 5, 200, "t1_five_frames");
        cont_en = 1'b0;
        for (int i = 1; i < start_cyc_q.size() && i < 5; i++)
            check("t1_spacing", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'(10));
        repeat (15) @(negedge clk);
        check("t1_drained", 32'(exp_q.size()), 32'(0));

        // Sparse mask: 1,3,1,3.
        ch_mask = 4'b1010;
        base = n_starts;
        push_exp(1); push_exp(3); push_exp(1); push_exp(3);
        cont_en = 1'b1;
        wait_starts(base + 4, 200, "t2_four_frames");
        cont_en = 1'b0;
        repeat (15) @(negedge clk);
        check("t2_drained", 32'(exp_q.size()), 32'(0));
        check("t2_overrun", 32'(overrun), 32'(0));

        // Empty mask: ticks ignored, no request, no overrun.
        ch_mask = 4'b0000;
        period = 24'd5;
        base = n_starts;
        hi = 0;
        cont_en = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (sns_req) hi++;
        end
        cont_en = 1'b0;
        check("t3_no_req", 32'(hi), 32'(0));
        check("t3_no_start", 32'(n_starts), 32'(base));
        check("t3_overrun", 32'(overrun), 32'(0));
        repeat (3) @(negedge clk);

        // Sensor silent: request held exactly ACK_TO cycles, then timeout.
        sns_en = 1'b0;
        ch_mask = 4'b1111;
        period = 24'd30;
        cont_en = 1'b1;
        wait_req(100, "t4_req_rise");
        check("t4_sns_ch0", 32'(sns_ch), 32'(0));
        hi = 0;
        do begin
            hi++;
            @(negedge clk);
        end while (sns_req && hi < 100);
        check("t4_req_len", 32'(hi), 32'(ACK_TO));
        check("t4_timeout_set", 32'(timeout), 32'(1));
        sns_en = 1'b1;
        base = n_starts;
        push_exp(1);
        wait_req(100, "t4_req2_rise");
        check("t4_sns_ch1", 32'(sns_ch), 32'(1));
        wait_starts(base + 1, 100, "t4_frame");
        cont_en = 1'b0;
        repeat (12) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_timeout_clr", 32'(timeout), 32'(0));

        // TX stuck busy with period 4: overrun, then a single frame on release.
        tx_block = 1'b1;
        ch_mask = 4'b1111;
        period = 24'd4;
        base = n_starts;
        push_exp(2);
        @(negedge clk);
        cont_en = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_overrun", 32'(overrun), 32'(1));
        check("t5_no_start_blocked", 32'(n_starts), 32'(base));
        tx_block = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (n_starts > base) cont_en = 1'b0;
        end
        cont_en = 1'b0;
        check("t5_one_start", 32'(n_starts - base), 32'(1));
        repeat (10) @(negedge clk);
        check("t5_drained", 32'(exp_q.size()), 32'(0));

        // Channel 2 alone: A5 on ch2, tx_start the cycle after ack.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t6_overrun_clr", 32'(overrun), 32'(0));
        ch_mask = 4'b0100;
        period = 24'd10;
        base = n_starts;
        push_exp(2);
        cont_en = 1'b1;
        wait_starts(base + 1, 100, "t6_frame");
        cont_en = 1'b0;
        if (start_cyc_q.size() > 0)
            check("t6_ack_to_start", 32'(start_cyc_q[$] - last_ack_cyc), 32'(1));
        repeat (12) @(negedge clk);
        check("t6_drained", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of a read, then polling restarts at ch0.
        sns_en = 1'b0;
        ch_mask = 4'b1111;
        cont_en = 1'b1;
        wait_req(100, "t7_req_rise");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t7_rst_sns_req", 32'(sns_req), 32'(0));
        check("t7_rst_tx_start", 32'(tx_start), 32'(0));
        check("t7_rst_tx_data", 32'(tx_data), 32'(0));
        check("t7_rst_overrun", 32'(overrun), 32'(0));
        check("t7_rst_timeout", 32'(timeout), 32'(0));
        repeat (2) @(negedge clk);
        sns_en = 1'b1;
        rst = 1'b1;
        base = n_starts;
        push_exp(0);
        wait_req(100, "t7_req_after_rst");
        check("t7_sns_ch0", 32'(sns_ch), 32'(0));
        wait_starts(base + 1, 100, "t7_frame");
        cont_en = 1'b0;
        repeat (12) @(negedge clk);
        check("t7_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
